acondicionador_botones: RTL
===========================

// Module: acondicionador_botones
// PURPOSE
//  Conditions the raw push-button inputs (arriba, abajo, izq, der, elige) before the game controller.
//  Per channel: metastability synchronizer, debounce state machine, one-cycle press pulse.
//  Outputs are a clean debounced level and a single-cycle press pulse, both in the 25 MHz system clock domain.
// PARAMETERS
//  N_BOTONES      5       number of independent button channels
//  SYNC_STAGES    2       synchronizer flip-flops per channel (>=2)
//  DB_CYCLES      250000  consecutive stable cycles needed to accept a new level (>=1; 10 ms at 25 MHz)
//  REPEAT_DELAY   6250000 cycles from the press pulse to the first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD  2500000 cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)
//  REPEAT_MASK    5'b01111 channels allowed to auto-repeat (directions yes, elige no)
// PORTS
//  clk          in   1          system clock, 25 MHz
//  reset_all    in   1          asynchronous, active-low reset
//  boton_in     in   N_BOTONES  raw asynchronous button levels, active-high
//  bloqueo      in   1          high: force all boton_pulso to 0; levels keep tracking
//  boton_nivel  out  N_BOTONES  debounced level
//  boton_pulso  out  N_BOTONES  one-cycle pulse per accepted press (and per repeat)
// BEHAVIOUR
//  Reset (reset_all=0, async)
//   - Sync flops, boton_nivel, boton_pulso, counters = 0.
//   - FSM = ESTABLE_BAJO.
//  Synchronizer
//   - The last stage (s) reflects boton_in after SYNC_STAGES edges.
//  Debounce FSM (per channel)
//   - States: ESTABLE_BAJO, VALIDANDO_ALTO, ESTABLE_ALTO, VALIDANDO_BAJO.
//   - ESTABLE_x -> VALIDANDO_y on the first edge where s != boton_nivel; cnt = 1.
//   - VALIDANDO_y:
//       s == boton_nivel -> return to ESTABLE_x, cnt = 0 (bounce rejected).
//       otherwise cnt increments; on the DB_CYCLES-th consecutive differing edge, boton_nivel toggles, state = ESTABLE_y, cnt = 0.
//   - DB_CYCLES=1: toggles on the first differing edge.
//  Latency
//   - boton_in held high from sampling edge 1: boton_nivel rises at edge SYNC_STAGES+DB_CYCLES.
//   - Release is symmetric.
//  Pulse
//   - boton_pulso[i] is registered and high exactly one cycle, in the same cycle boton_nivel[i] goes 0->1, unless bloqueo=1.
//   - A 1->0 transition never pulses.
//  Channels
//   - Fully independent; simultaneous presses pulse in the same cycle.
//  Reset mid-operation
//   - All debounce progress is discarded.
//   - A button held through reset release pulses after the full latency, counted from the first edge after release.
//  Counter width
//   - $clog2(DB_CYCLES+1); saturation is never reached because cnt clears on toggle.
// CONFIGURATION
//  `AUTO_REPEAT_EN defined
//   - For channels with REPEAT_MASK[i]=1, while boton_nivel[i] stays high: extra pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
//   - Release (nivel 1->0) stops repeats and clears the repeat counter the same cycle.
//   - bloqueo suppresses repeat pulses but does not stop the repeat counter.
//  `AUTO_REPEAT_EN undefined
//   - Exactly one pulse per accepted press; no repeat logic synthesized.
//   - REPEAT_* parameters are ignored.
// STRUCTURE
//  Package gato_pkg:
//   - button index constants BTN_ARRIBA=0, BTN_ABAJO=1, BTN_IZQ=2, BTN_DER=3, BTN_ELIGE=4.
//   - debounce state encoding (2-bit typedef).
//   - DB_CYCLES_25MHZ constant.
//  Sub-module antirrebote_canal:
//   - one channel (synchronizer + FSM + pulse + optional repeat).
//   - generate-instantiated N_BOTONES times; top adds only the bloqueo gating.
// TESTING  (bench params: SYNC_STAGES=2, DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Clean press: boton_in[0] 0->1 and hold -> nivel[0] and pulso[0] rise at edge 6, pulso high 1 cycle;
//    release -> nivel[0] falls 6 edges later, no pulse.
//  2 Bounce: boton_in[2] high 3 cycles then low -> nivel[2] and pulso[2] stay 0;
//    FSM returns to ESTABLE_BAJO.
//  3 Blocked press: bloqueo=1, press boton_in[4] -> nivel[4] rises at edge 6, pulso[4] stays 0.
//  4 Reset mid-count: hold boton_in[1], assert reset_all=0 at edge 3, release with input still high ->
//    outputs 0 during reset, pulso[1] at edge 6 after release.
//  5 Simultaneous: boton_in=5'b11111 in one cycle -> pulso=5'b11111 for exactly one cycle at edge 6.
//  6 Auto-repeat (AUTO_REPEAT_EN): hold boton_in[3] 30 cycles -> pulses at t0, t0+10, t0+13, t0+16, ...;
//    hold boton_in[4] -> single pulse;
//    macro undefined -> boton_in[3] gives a single pulse.

Source files
------------

// File: rtl/gato_pkg.sv
// Shared definitions for the game controller front end: button indices,
// debounce state encoding and the 10 ms debounce constant at 25 MHz.
package gato_pkg;

  localparam int BTN_ARRIBA = 0;
  localparam int BTN_ABAJO  = 1;
  localparam int BTN_IZQ    = 2;
  localparam int BTN_DER    = 3;
  localparam int BTN_ELIGE  = 4;

  localparam int N_BOTONES_DEF   = BTN_ELIGE + 1;
  localparam int DB_CYCLES_25MHZ = 250000;

  // Directions auto-repeat, the select button never does.
  localparam logic [N_BOTONES_DEF-1:0] REPEAT_MASK_DEF = N_BOTONES_DEF'(
      (1 << BTN_ARRIBA) | (1 << BTN_ABAJO) | (1 << BTN_IZQ) | (1 << BTN_DER));

  typedef enum logic [1:0] {
    ESTABLE_BAJO   = 2'd0,
    VALIDANDO_ALTO = 2'd1,
    ESTABLE_ALTO   = 2'd2,
    VALIDANDO_BAJO = 2'd3
  } estado_db_t;

endpackage

// File: rtl/acondicionador_botones_if.sv
// Button bundle between the raw panel side (master) and the conditioner (slave).
interface acondicionador_botones_if #(
  parameter int N_BOTONES = 5
);
  logic [N_BOTONES-1:0] boton_in;
  logic                 bloqueo;
  logic [N_BOTONES-1:0] boton_nivel;
  logic [N_BOTONES-1:0] boton_pulso;

  modport master (
    output boton_in,
    output bloqueo,
    input  boton_nivel,
    input  boton_pulso
  );

  modport slave (
    input  boton_in,
    input  bloqueo,
    output boton_nivel,
    output boton_pulso
  );
endinterface

// File: rtl/acondicionador_botones_antirrebote_canal.sv
// One button channel: synchronizer, debounce FSM, press pulse and, when
// AUTO_REPEAT_EN is defined, the hold-to-repeat pulse generator.
module antirrebote_canal
  import gato_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = DB_CYCLES_25MHZ
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 6250000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter bit REPEAT_HAB    = 1'b1
`endif
) (
  input  logic clk,
  input  logic reset_all,
  input  logic boton,
  output logic nivel,
  output logic pulso
);

  localparam int                CNT_W   = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  estado_db_t             estado_reg, estado_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next, cnt_mas1;
  logic                   nivel_reg, nivel_next;
  logic                   pulso_reg, pulso_next;
  logic                   acepta;

  assign s        = sync_reg[SYNC_STAGES-1];
  assign cnt_mas1 = cnt_reg + CNT_UNO;

`ifdef AUTO_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next, rep_mas1, rep_fin;
  logic             primero_reg, primero_next;

  assign rep_mas1 = rep_cnt_reg + REP_W'(1);
  assign rep_fin  = primero_reg ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);
`endif

  always_comb begin
    estado_next = estado_reg;
    cnt_next    = cnt_reg;
    nivel_next  = nivel_reg;
    acepta      = 1'b0;

    case (estado_reg)
      ESTABLE_BAJO, ESTABLE_ALTO: begin
        if (s != nivel_reg) begin
          if (CNT_UNO == CNT_FIN) begin
            acepta = 1'b1;
          end else begin
            estado_next = nivel_reg ? VALIDANDO_BAJO : VALIDANDO_ALTO;
            cnt_next    = CNT_UNO;
          end
        end
      end
      default: begin
        if (s == nivel_reg) begin
          // Bounce: input went back before the window closed.
          estado_next = nivel_reg ? ESTABLE_ALTO : ESTABLE_BAJO;
          cnt_next    = '0;
        end else if (cnt_mas1 == CNT_FIN) begin
          acepta = 1'b1;
        end else begin
          cnt_next = cnt_mas1;
        end
      end
    endcase

    if (acepta) begin
      nivel_next  = ~nivel_reg;
      estado_next = nivel_reg ? ESTABLE_BAJO : ESTABLE_ALTO;
      cnt_next    = '0;
    end

    pulso_next = acepta & ~nivel_reg;

`ifdef AUTO_REPEAT_EN
    rep_cnt_next = rep_cnt_reg;
    primero_next = primero_reg;
    if (!REPEAT_HAB) begin
      rep_cnt_next = '0;
      primero_next = 1'b0;
    end else if (pulso_next) begin
      rep_cnt_next = '0;
      primero_next = 1'b1;
    end else if (nivel_reg && nivel_next) begin
      if (rep_mas1 == rep_fin) begin
        pulso_next   = 1'b1;
        rep_cnt_next = '0;
        primero_next = 1'b0;
      end else begin
        rep_cnt_next = rep_mas1;
      end
    end else begin
      rep_cnt_next = '0;
      primero_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      sync_reg   <= '0;
      estado_reg <= ESTABLE_BAJO;
      cnt_reg    <= '0;
      nivel_reg  <= 1'b0;
      pulso_reg  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt_reg <= '0;
      primero_reg <= 1'b0;
`endif
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], boton};
      estado_reg <= estado_next;
      cnt_reg    <= cnt_next;
      nivel_reg  <= nivel_next;
      pulso_reg  <= pulso_next;
`ifdef AUTO_REPEAT_EN
      rep_cnt_reg <= rep_cnt_next;
      primero_reg <= primero_next;
`endif
    end
  end

  assign nivel = nivel_reg;
  assign pulso = pulso_reg;

endmodule

// File: rtl/acondicionador_botones.sv
// Push-button conditioner: N independent debounce channels plus bloqueo gating.
// Optional hold-to-repeat pulses are built only when AUTO_REPEAT_EN is defined.
module acondicionador_botones
  import gato_pkg::*;
#(
  parameter int N_BOTONES     = N_BOTONES_DEF,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = DB_CYCLES_25MHZ,
  parameter int REPEAT_DELAY  = 6250000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter logic [N_BOTONES-1:0] REPEAT_MASK = N_BOTONES'(REPEAT_MASK_DEF)
) (
  input logic                     clk,
  input logic                     reset_all,
  acondicionador_botones_if.slave botones
);

  logic [N_BOTONES-1:0] nivel_canal;
  logic [N_BOTONES-1:0] pulso_canal;

  for (genvar gi = 0; gi < N_BOTONES; gi++) begin : g_canal
    antirrebote_canal #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DB_CYCLES     (DB_CYCLES)
`ifdef AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REPEAT_HAB    (REPEAT_MASK[gi])
`endif
    ) u_canal (
      .clk       (clk),
      .reset_all (reset_all),
      .boton     (botones.boton_in[gi]),
      .nivel     (nivel_canal[gi]),
      .pulso     (pulso_canal[gi])
    );
  end

`ifndef AUTO_REPEAT_EN
  // Without auto-repeat the REPEAT_* settings have no effect; this empty
  // block only keeps them referenced.
  if (REPEAT_DELAY < 0 && REPEAT_PERIOD < 0 && REPEAT_MASK == '0) begin : g_repeat_sin_uso
  end
`endif

  // Levels keep tracking under bloqueo; only the pulses are masked.
  assign botones.boton_nivel = nivel_canal;
  assign botones.boton_pulso = pulso_canal & {N_BOTONES{~botones.bloqueo}};

endmodule
